rx_udp: RTL

- Receive-path stage directly downstream of the IPv4 receiver.
- Consumes the IPv4 payload byte stream, qualified by rx_data_udp (asserted only for protocol 0x11).
- Parses the 8-byte UDP header (src port, dst port, length, checksum) and optionally filters on destination port.
- Emits the UDP payload as a byte stream with start/end markers, and reports truncated datagrams.

---
 rtl/rx_udp_pkg.sv | 17 +
 rtl/rx_udp_if.sv | 29 ++
 rtl/rx_udp.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rx_udp_pkg.sv
// Shared definitions for the UDP receive stage.
// Covers parser state encodings and protocol constants.
package udp_pkg;

    typedef enum logic [2:0] {
        SRC_PORT,
        DST_PORT,
        LEN,
        CSUM,
        DATA,
        DROP
    } state_t;

    localparam logic [15:0] UDP_HDR_LEN = 16'd8;
    localparam logic [7:0]  UDP_PROTO   = 8'h11;

endpackage

// File: rtl/rx_udp_if.sv
// Byte-stream bundle between the IPv4 receiver, the UDP parser and its consumer.
// The slave modport is the parser's view; master is the surrounding environment.
interface rx_udp_if #(parameter int OCT = 8);

    logic [15:0]    udp_port;
    logic           rx_data_udp;
    logic [OCT-1:0] rx_data;
    logic [15:0]    rx_src_port;
    logic [15:0]    rx_dst_port;
    logic [15:0]    rx_udp_len;
    logic           rx_udp_valid;
    logic [OCT-1:0] rx_udp_data;
    logic           rx_udp_sof;
    logic           rx_udp_eof;
    logic           rx_udp_err;

    modport master (
        output udp_port, rx_data_udp, rx_data,
        input  rx_src_port, rx_dst_port, rx_udp_len,
        input  rx_udp_valid, rx_udp_data, rx_udp_sof, rx_udp_eof, rx_udp_err
    );

    modport slave (
        input  udp_port, rx_data_udp, rx_data,
        output rx_src_port, rx_dst_port, rx_udp_len,
        output rx_udp_valid, rx_udp_data, rx_udp_sof, rx_udp_eof, rx_udp_err
    );

endinterface

// File: rtl/rx_udp.sv
// UDP header parser with optional destination-port filter.
// Strips the 8-byte header and streams the payload with sof/eof and truncation errors.
module rx_udp
    import udp_pkg::*;
#(
    parameter int OCT         = 8,
    parameter bit PORT_FILTER = 1'b1
) (
    input  logic     RX_CLK,
    input  logic     rst_n,
    rx_udp_if.slave  bus
);

    state_t         state_reg, state_next;
    logic           cnt_reg, cnt_next;
    logic [15:0]    field_reg, field_next;
    logic [15:0]    remaining_reg, remaining_next;
    logic           drop_reg, drop_next;
    logic           first_reg, first_next;
    logic [15:0]    src_port_reg, src_port_next;
    logic [15:0]    dst_port_reg, dst_port_next;
    logic [15:0]    len_reg, len_next;
    logic           valid_reg, valid_next;
    logic [OCT-1:0] data_reg, data_next;
    logic           sof_reg, sof_next;
    logic           eof_reg, eof_next;
    logic           err_reg, err_next;
    logic [15:0]    field_shift;

    // field_reg keeps the last header field, so the checksum stays latched after CSUM.
    assign field_shift = {field_reg[7:0], bus.rx_data};

    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SRC_PORT;
            cnt_reg       <= 1'b0;
            field_reg     <= '0;
            remaining_reg <= '0;
            drop_reg      <= 1'b0;
            first_reg     <= 1'b0;
            src_port_reg  <= '0;
            dst_port_reg  <= '0;
            len_reg       <= '0;
            valid_reg     <= 1'b0;
            data_reg      <= '0;
            sof_reg       <= 1'b0;
            eof_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            field_reg     <= field_next;
            remaining_reg <= remaining_next;
            drop_reg      <= drop_next;
            first_reg     <= first_next;
            src_port_reg  <= src_port_next;
            dst_port_reg  <= dst_port_next;
            len_reg       <= len_next;
            valid_reg     <= valid_next;
            data_reg      <= data_next;
            sof_reg       <= sof_next;
            eof_reg       <= eof_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        field_next     = field_reg;
        remaining_next = remaining_reg;
        drop_next      = drop_reg;
        first_next     = first_reg;
        src_port_next  = src_port_reg;
        dst_port_next  = dst_port_reg;
        len_next       = len_reg;
        valid_next     = 1'b0;
        data_next      = data_reg;
        sof_next       = 1'b0;
        eof_next       = 1'b0;
        err_next       = 1'b0;

        if (bus.rx_data_udp) begin
            case (state_reg)
                SRC_PORT: begin
                    field_next = field_shift;
                    cnt_next   = ~cnt_reg;
                    if (cnt_reg) begin
                        src_port_next = field_shift;
                        state_next    = DST_PORT;
                    end else begin
                        drop_next = 1'b0;
                    end
                end
                DST_PORT: begin
                    field_next = field_shift;
                    cnt_next   = ~cnt_reg;
                    if (cnt_reg) begin
                        dst_port_next = field_shift;
                        drop_next     = PORT_FILTER && (field_shift != bus.udp_port);
                        state_next    = LEN;
                    end
                end
                LEN: begin
                    field_next = field_shift;
                    cnt_next   = ~cnt_reg;
                    if (cnt_reg) begin
                        len_next = field_shift;
                        if (field_shift < UDP_HDR_LEN) begin
                            err_next   = 1'b1;
                            state_next = DROP;
                        end else begin
                            remaining_next = field_shift - UDP_HDR_LEN;
                            state_next     = CSUM;
                        end
                    end
                end
                CSUM: begin
                    field_next = field_shift;
                    cnt_next   = ~cnt_reg;
                    if (cnt_reg) begin
                        if (drop_reg || remaining_reg == 16'd0) begin
                            state_next = DROP;
                        end else begin
                            first_next = 1'b1;
                            state_next = DATA;
                        end
                    end
                end
                DATA: begin
                    valid_next     = 1'b1;
                    data_next      = bus.rx_data;
                    sof_next       = first_reg;
                    first_next     = 1'b0;
                    remaining_next = remaining_reg - 16'd1;
                    if (remaining_reg == 16'd1) begin
                        eof_next   = 1'b1;
                        state_next = DROP;
                    end
                end
                DROP: ;
                default: state_next = SRC_PORT;
            endcase
        end else if (state_reg == DROP) begin
            state_next = SRC_PORT;
        end else if (!(state_reg == SRC_PORT && !cnt_reg)) begin
            // Strobe fell mid-header or mid-payload: the datagram was cut short.
            err_next   = 1'b1;
            cnt_next   = 1'b0;
            first_next = 1'b0;
            state_next = SRC_PORT;
        end
    end

    assign bus.rx_src_port  = src_port_reg;
    assign bus.rx_dst_port  = dst_port_reg;
    assign bus.rx_udp_len   = len_reg;
    assign bus.rx_udp_valid = valid_reg;
    assign bus.rx_udp_data  = data_reg;
    assign bus.rx_udp_sof   = sof_reg;
    assign bus.rx_udp_eof   = eof_reg;
    assign bus.rx_udp_err   = err_reg;

endmodule
